// File: rtl/coder_pkg.sv
// Shared constants, FSM state type and Hamming(7,4) syndrome helper used by the
// spread-spectrum coder and the hamming_decoder receive path.
package coder_pkg;

    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_ZERO = 2'b11;
    localparam logic [1:0] SYM_IDLE = 2'b10;

    // x^5 + x^2 + 1: the new MSB is lfsr[0] ^ lfsr[2]
    localparam logic [4:0] LFSR_SEED = 5'b00001;
    localparam logic [4:0] LFSR_TAPS = 5'b00101;

    localparam int CHIPS_PER_BIT = 31;
    localparam int BIT_THRESH    = (CHIPS_PER_BIT + 1) / 2;
    localparam int HEAD_ONES_MIN = 10;
    localparam int FSYNC_LEN     = 7;
    localparam int CW_LEN        = 7;
    localparam int CW_PER_FRAME  = 32;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_FSYNC = 2'd1,
        ST_DATA  = 2'd2
    } sync_state_e;

    localparam logic [2:0] SYN_NONE = 3'b000;
    localparam logic [2:0] SYN_D3   = 3'b101;
    localparam logic [2:0] SYN_D2   = 3'b111;
    localparam logic [2:0] SYN_D1   = 3'b110;
    localparam logic [2:0] SYN_D0   = 3'b011;

    // cw = {d3, d2, d1, d0, p1, p2, p3}
    function automatic logic [2:0] hamming_syndrome(input logic [6:0] cw);
        return {cw[2] ^ cw[6] ^ cw[5] ^ cw[4],
                cw[1] ^ cw[5] ^ cw[4] ^ cw[3],
                cw[0] ^ cw[6] ^ cw[5] ^ cw[3]};
    endfunction

endpackage

// File: rtl/despread_corr.sv
// Chip-rate despreader: correlates 31 chips against the m-sequence and emits a
// majority-vote bit decision with a one-cycle valid strobe.
module despread_corr
    import coder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic chip_i,
    input  logic abort_i,
    output logic bit_o,
    output logic bit_valid_o
);

    logic [4:0] lfsr_q, lfsr_d;
    logic [4:0] chip_cnt_q, chip_cnt_d;
    logic [4:0] ones_q, ones_d;
    logic       bit_q, bit_d;
    logic       bit_valid_q, bit_valid_d;
    logic       dchip;
    logic [5:0] ones_sum;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        lfsr_d      = lfsr_q;
        chip_cnt_d  = chip_cnt_q;
        ones_d      = ones_q;
        bit_d       = bit_q;
        bit_valid_d = 1'b0;
        dchip       = chip_i ^ lfsr_q[0];
        ones_sum    = {1'b0, ones_q} + {5'b0, dchip};

        if (abort_i) begin
            lfsr_d     = LFSR_SEED;
            chip_cnt_d = '0;
            ones_d     = '0;
        end else if (chip_cnt_q == 5'(CHIPS_PER_BIT - 1)) begin
            bit_valid_d = 1'b1;
            bit_d       = (ones_sum >= 6'(BIT_THRESH));
            lfsr_d      = LFSR_SEED;
            chip_cnt_d  = '0;
            ones_d      = '0;
        end else begin
            lfsr_d     = {^(lfsr_q & LFSR_TAPS), lfsr_q[4:1]};
            chip_cnt_d = chip_cnt_q + 5'd1;
            ones_d     = ones_sum[4:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q      <= LFSR_SEED;
            chip_cnt_q  <= '0;
            ones_q      <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            chip_cnt_q  <= chip_cnt_d;
            ones_q      <= ones_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign bit_o       = bit_q;
    assign bit_valid_o = bit_valid_q;

endmodule

// File: rtl/hamming_decoder.sv
// Receive path: despread, head/frame sync acquisition and Hamming(7,4) decode.
// Define HAMMING_CORRECT_EN for single-error correction; otherwise detect-only.
module hamming_decoder
    import coder_pkg::*;
(
    input  logic       clk1,
    input  logic       rst,
    input  logic [1:0] in_sym,
    output logic [3:0] out_nibble,
    output logic       out_valid,
    output logic       corr_err,
    output logic       frame_lock,
    output logic       sync_err
);

    logic [1:0]  sym_q;
    logic        chip, sym_idle_q, idle_now;
    logic        rx_bit, rx_bit_valid;

    sync_state_e state_q, state_d;
    logic [3:0]  head_cnt_q, head_cnt_d;
    logic [2:0]  fs_cnt_q, fs_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [4:0]  cw_cnt_q, cw_cnt_d;
    logic [5:0]  cw_q, cw_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        valid_q, valid_d;
    logic        corr_q, corr_d;
    logic        sync_err_q, sync_err_d;
    logic        lock_q, lock_d;

    logic [6:0]  word;
    logic [2:0]  syn;
    logic [3:0]  data_fix;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) sym_q <= SYM_IDLE;
        else     sym_q <= in_sym;
    end

    // Illegal 2'b00 falls through to chip 0.
    assign chip       = (sym_q == SYM_ONE);
    assign sym_idle_q = (sym_q == SYM_IDLE);
    assign idle_now   = (in_sym == SYM_IDLE);

    despread_corr u_despread (
        .clk         (clk1),
        .rst         (rst),
        .chip_i      (chip),
        .abort_i     (sym_idle_q),
        .bit_o       (rx_bit),
        .bit_valid_o (rx_bit_valid)
    );

    assign word = {cw_q, rx_bit};
    assign syn  = hamming_syndrome(word);

    always_comb begin
        data_fix = word[6:3];
`ifdef HAMMING_CORRECT_EN
        case (syn)
            SYN_D3:  data_fix[3] = ~word[6];
            SYN_D2:  data_fix[2] = ~word[5];
            SYN_D1:  data_fix[1] = ~word[4];
            SYN_D0:  data_fix[0] = ~word[3];
            default: data_fix = word[6:3];
        endcase
`endif
    end

    always_comb begin
        state_d    = state_q;
        head_cnt_d = head_cnt_q;
        fs_cnt_d   = fs_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        cw_cnt_d   = cw_cnt_q;
        cw_d       = cw_q;
        nibble_d   = nibble_q;
        valid_d    = 1'b0;
        corr_d     = 1'b0;
        sync_err_d = 1'b0;

        if (idle_now) begin
            state_d    = ST_HUNT;
            head_cnt_d = '0;
            fs_cnt_d   = '0;
            bit_cnt_d  = '0;
            cw_cnt_d   = '0;
            cw_d       = '0;
        end else if (rx_bit_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (rx_bit) begin
                        if (head_cnt_q != 4'hF) head_cnt_d = head_cnt_q + 4'd1;
                    end else if (head_cnt_q >= 4'(HEAD_ONES_MIN)) begin
                        state_d    = ST_FSYNC;
                        head_cnt_d = '0;
                        fs_cnt_d   = '0;
                    end else begin
                        head_cnt_d = '0;
                    end
                end
                ST_FSYNC: begin
                    if (rx_bit) begin
                        state_d    = ST_HUNT;
                        sync_err_d = 1'b1;
                        head_cnt_d = '0;
                    end else if (fs_cnt_q == 3'(FSYNC_LEN - 1)) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        cw_cnt_d  = '0;
                    end else begin
                        fs_cnt_d = fs_cnt_q + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_q == 3'(CW_LEN - 1)) begin
                        nibble_d  = data_fix;
                        valid_d   = 1'b1;
                        corr_d    = (syn != SYN_NONE);
                        bit_cnt_d = '0;
                        if (cw_cnt_q == 5'(CW_PER_FRAME - 1)) begin
                            state_d  = ST_FSYNC;
                            fs_cnt_d = '0;
                        end else begin
                            cw_cnt_d = cw_cnt_q + 5'd1;
                        end
                    end else begin
                        cw_d      = word[5:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // Lock is gained on entering DATA and held through the per-frame resync.
        lock_d = lock_q;
        if (state_d == ST_HUNT)      lock_d = 1'b0;
        else if (state_d == ST_DATA) lock_d = 1'b1;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            head_cnt_q <= '0;
            fs_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            cw_cnt_q   <= '0;
            cw_q       <= '0;
            nibble_q   <= '0;
            valid_q    <= 1'b0;
            corr_q     <= 1'b0;
            sync_err_q <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_cnt_q <= head_cnt_d;
            fs_cnt_q   <= fs_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            cw_cnt_q   <= cw_cnt_d;
            cw_q       <= cw_d;
            nibble_q   <= nibble_d;
            valid_q    <= valid_d;
            corr_q     <= corr_d;
            sync_err_q <= sync_err_d;
            lock_q     <= lock_d;
        end
    end

    assign out_nibble = nibble_q;
    assign out_valid  = valid_q;
    assign corr_err   = corr_q;
    assign sync_err   = sync_err_q;
    assign frame_lock = lock_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: spreads hand-chosen codewords, checks
// nibbles, pulses, sync behaviour, latency, abort and reset recovery.
module tb_hamming_decoder;
    import coder_pkg::*;

    logic       clk1 = 1'b0;
    logic       rst;
    logic [1:0] in_sym;
    logic [3:0] out_nibble;
    logic       out_valid, corr_err, frame_lock, sync_err;

    hamming_decoder dut (
        .clk1       (clk1),
        .rst        (rst),
        .in_sym     (in_sym),
        .out_nibble (out_nibble),
        .out_valid  (out_valid),
        .corr_err   (corr_err),
        .frame_lock (frame_lock),
        .sync_err   (sync_err)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // m-sequence by recurrence s[n+5] = s[n+2] ^ s[n], first five = 1,0,0,0,0
    logic [30:0] mseq;

    // Monitor state
    int   vcount = 0, scount = 0, lrise = 0, lock_drop = 0, wide = 0, stray = 0;
    int   sync_cyc = 0, rise_cyc = 0;
    logic prev_valid = 1'b0, prev_lock = 1'b0, watch_lock = 1'b0;
    logic [3:0] last_nib = '0;
    int   got_nib[$], got_corr[$], got_cyc[$];
    int   exp_nib[$], exp_corr[$];

    always @(negedge clk1) begin
        if (out_valid) begin
            vcount++;
            last_nib = out_nibble;
            got_nib.push_back(int'(out_nibble));
            got_corr.push_back(int'(corr_err));
            got_cyc.push_back(cyc);
            if (prev_valid) wide++;
        end
        if (corr_err && !out_valid) stray++;
        if (sync_err) begin
            scount++;
            sync_cyc = cyc;
        end
        if (frame_lock && !prev_lock) begin
            lrise++;
            rise_cyc = cyc;
        end
        if (watch_lock && !frame_lock) lock_drop++;
        prev_valid = out_valid;
        prev_lock  = frame_lock;
    end

    int n_edge = 0;

    task automatic send_sym(input logic [1:0] s);
        in_sym = s;
        @(posedge clk1);
        #1;
    endtask

    task automatic send_chips(input logic b, input int n, input logic noisy);
        for (int k = 0; k < n; k++) begin
            logic c;
            c = b ^ mseq[k];
            if (noisy && (k % 2 == 0) && k < 30) c = ~c;
            if (c) send_sym(SYM_ONE);
            else   send_sym(noisy ? 2'b00 : SYM_ZERO);
        end
        n_edge = cyc;
    endtask

    task automatic send_bit(input logic b, input logic noisy);
        send_chips(b, 31, noisy);
    endtask

    task automatic send_word(input logic [6:0] w, input logic noisy);
        for (int i = 6; i >= 0; i--) send_bit(w[i], noisy);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_sym(SYM_IDLE);
    endtask

    task automatic send_head_fsync(output int fs_edge);
        send_idle(3);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        fs_edge = n_edge;
    endtask

    // Codeword table with hand-computed results
    logic [6:0] tv_cw   [8];
    logic [3:0] tv_corr_nib [8];
    logic [3:0] tv_raw_nib  [8];
    logic       tv_corr [8];

    function automatic logic [3:0] exp_of(input int idx);
`ifdef HAMMING_CORRECT_EN
        return tv_corr_nib[idx];
`else
        return tv_raw_nib[idx];
`endif
    endfunction

    int v0, s0, l0, n_fs, n_cw0, n_sync;

    initial begin
        mseq[0] = 1'b1;
        for (int i = 1; i < 5; i++) mseq[i] = 1'b0;
        for (int n = 0; n < 26; n++) mseq[n+5] = mseq[n+2] ^ mseq[n];

        tv_cw[0] = 7'b1011000; tv_corr_nib[0] = 4'b1011; tv_raw_nib[0] = 4'b1011; tv_corr[0] = 1'b0;
        tv_cw[1] = 7'b1111000; tv_corr_nib[1] = 4'b1011; tv_raw_nib[1] = 4'b1111; tv_corr[1] = 1'b1;
        tv_cw[2] = 7'b0110001; tv_corr_nib[2] = 4'b0110; tv_raw_nib[2] = 4'b0110; tv_corr[2] = 1'b0;
        tv_cw[3] = 7'b1011000; tv_corr_nib[3] = 4'b1011; tv_raw_nib[3] = 4'b1011; tv_corr[3] = 1'b0;
        tv_cw[4] = 7'b0000000; tv_corr_nib[4] = 4'b0000; tv_raw_nib[4] = 4'b0000; tv_corr[4] = 1'b0;
        tv_cw[5] = 7'b1111111; tv_corr_nib[5] = 4'b1111; tv_raw_nib[5] = 4'b1111; tv_corr[5] = 1'b0;
        tv_cw[6] = 7'b0110011; tv_corr_nib[6] = 4'b0110; tv_raw_nib[6] = 4'b0110; tv_corr[6] = 1'b1;
        tv_cw[7] = 7'b0011000; tv_corr_nib[7] = 4'b1011; tv_raw_nib[7] = 4'b0011; tv_corr[7] = 1'b1;

        // Reset state
        rst    = 1'b1;
        in_sym = SYM_IDLE;
        repeat (3) @(posedge clk1);
        #1;
        check("rst_valid",  32'(out_valid),  32'd0);
        check("rst_nibble", 32'(out_nibble), 32'd0);
        check("rst_corr",   32'(corr_err),   32'd0);
        check("rst_lock",   32'(frame_lock), 32'd0);
        check("rst_syncerr", 32'(sync_err),  32'd0);
        rst = 1'b0;

        // Frame-sync failure: head then 0001000
        v0 = vcount; s0 = scount; l0 = lrise;
        send_idle(3);
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        n_sync = n_edge;
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        check("fsfail_syncerr_cnt", 32'(scount - s0), 32'd1);
        check("fsfail_syncerr_lat", 32'(sync_cyc - n_sync), 32'd2);
        check("fsfail_no_valid", 32'(vcount - v0), 32'd0);
        check("fsfail_no_lock_rise", 32'(lrise - l0), 32'd0);
        check("fsfail_lock", 32'(frame_lock), 32'd0);

        // Full frame: 32 codewords (incl. error and noisy ones), resync, one more
        got_nib.delete(); got_corr.delete(); got_cyc.delete();
        exp_nib.delete(); exp_corr.delete();
        v0 = vcount; s0 = scount;
        send_head_fsync(n_fs);
        for (int i = 0; i < 32; i++) begin
            int idx;
            idx = i % 8;
            send_word(tv_cw[idx], (idx == 2) || (idx == 3));
            exp_nib.push_back(int'(exp_of(idx)));
            exp_corr.push_back(int'(tv_corr[idx]));
            if (i == 0) begin
                n_cw0 = n_edge;
                check("clean_lock", 32'(frame_lock), 32'd1);
                watch_lock = 1'b1;
            end
        end
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        send_word(7'b0110001, 1'b0);
        exp_nib.push_back(int'(4'b0110));
        exp_corr.push_back(0);
        send_bit(1'b0, 1'b0);
        watch_lock = 1'b0;
        check("frame_valid_cnt", 32'(vcount - v0), 32'd33);
        check("frame_lat", 32'(got_cyc[0] - n_cw0), 32'd2);
        check("lock_rise_lat", 32'(rise_cyc - n_fs), 32'd2);
        check("frame_lock_held", 32'(lock_drop), 32'd0);
        check("frame_final_nib", 32'(last_nib), 32'(4'b0110));
        check("frame_no_syncerr", 32'(scount - s0), 32'd0);
        for (int i = 0; i < exp_nib.size(); i++) begin
            check($sformatf("nib[%0d]", i), 32'(got_nib[i]), 32'(exp_nib[i]));
            check($sformatf("corr[%0d]", i), 32'(got_corr[i]), 32'(exp_corr[i]));
        end

        // Abort: idle at chip 12 of the 4th codeword bit
        v0 = vcount;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_chips(1'b1, 12, 1'b0);
        send_idle(1);
        check("abort_lock_fall", 32'(frame_lock), 32'd0);
        send_idle(4);
        check("abort_no_valid", 32'(vcount - v0), 32'd0);
        send_head_fsync(n_fs);
        send_word(7'b0101100, 1'b0);
        send_bit(1'b0, 1'b0);
        check("reacq_valid_cnt", 32'(vcount - v0), 32'd1);
        check("reacq_nib", 32'(last_nib), 32'(4'b0101));
        check("reacq_corr", 32'(got_corr[got_corr.size()-1]), 32'd0);
        check("reacq_lock", 32'(frame_lock), 32'd1);

        // Reset mid-codeword
        v0 = vcount;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_chips(1'b1, 10, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_nibble", 32'(out_nibble), 32'd0);
        check("midrst_lock",   32'(frame_lock), 32'd0);
        check("midrst_valid",  32'(out_valid),  32'd0);
        for (int i = 0; i < 3; i++) send_sym(SYM_ONE);
        rst = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        check("midrst_no_valid", 32'(vcount - v0), 32'd0);
        check("midrst_lock_low", 32'(frame_lock), 32'd0);
        send_head_fsync(n_fs);
        send_word(7'b1011000, 1'b0);
        send_bit(1'b0, 1'b0);
        check("rstacq_valid_cnt", 32'(vcount - v0), 32'd1);
        check("rstacq_nib", 32'(last_nib), 32'(4'b1011));
        send_idle(2);

        check("valid_one_cycle", 32'(wide), 32'd0);
        check("corr_only_with_valid", 32'(stray), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
